// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage of the 16-bit 4-stage pipeline.
package fetch_pkg;

   localparam logic [15:0] PC_INC           = 16'd2;
   localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;

   typedef enum logic [1:0] {
      S_RESET,
      S_RUN,
      S_STALL,
      S_REDIRECT
   } fetch_state_e;

   // Saturating increment for the optional performance counters.
   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read port between the fetch stage and the synchronous imem.
// Protocol: a read is requested in any cycle o_mem_rd=1 for o_mem_addr; i_mem_rddata
// carries that word exactly one cycle later; there is no backpressure (always ready).
interface fetch_unit_if;
   logic [15:0] o_mem_addr;
   logic        o_mem_rd;
   logic [15:0] i_mem_rddata;

   modport master (output o_mem_addr, output o_mem_rd, input i_mem_rddata);
   modport slave  (input o_mem_addr, input o_mem_rd, output i_mem_rddata);
endinterface

// File: rtl/fetch_ir_hold.sv
// IR hold register: keeps the rf_read-stage instruction word while the stage is stalled,
// because imem keeps returning the re-read fetch-stage word during the stall.
module fetch_ir_hold
   import fetch_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        capture,
   input  logic        select,
   input  logic [15:0] i_mem_rddata,
   output logic [15:0] ir
);

   logic [15:0] hold_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         hold_q <= '0;
      end else if (capture) begin
         hold_q <= i_mem_rddata;
      end
   end

   assign ir = select ? hold_q : i_mem_rddata;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC register, imem read port and the fetch/rf_read pipeline registers.
// Optional FETCH_PERF_CNT_EN adds saturating advance/redirect counters.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [15:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int          PC_W     = 16
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              i_stall,
   input  logic              branch_sig,
   input  logic [PC_W-1:0]   pc_in_br,
   input  logic              set_invalid_sig_to_fetch,
   input  logic              set_invalid_sig_to_rf_read,
   fetch_unit_if.master      mem,
   output logic [PC_W-1:0]   o_pc_out_in_fetch_stage,
   output logic              o_valid_in_fetch_stage,
   output logic [PC_W-1:0]   o_pc_in_rf_read_stage,
   output logic [PC_W-1:0]   o_ir_in_rf_read_stage,
   output logic              o_valid_in_rf_read_stage,
   output fetch_state_e      o_state
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [15:0]       o_fetch_cnt,
   output logic [15:0]       o_redirect_cnt
`endif
);

   fetch_state_e    state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d, next_pc;
   logic [PC_W-1:0] rf_pc_q, rf_pc_d;
   logic            rf_valid_q, rf_valid_d;
   logic            after_stall_q;
   logic            fetch_valid;
   logic            redirect;
   logic            capture, select;

   assign redirect = set_invalid_sig_to_fetch;
   assign next_pc  = (branch_sig | redirect) ? pc_in_br : pc_q + PC_INC;

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      rf_pc_d     = rf_pc_q;
      rf_valid_d  = rf_valid_q;
      fetch_valid = 1'b0;
      case (state_q)
         S_RESET: begin
            state_d = S_RUN;
         end
         S_RUN, S_REDIRECT: begin
            fetch_valid = 1'b1;
            // An execute redirect beats a stall; a fetch-only redirect waits for it.
            if (set_invalid_sig_to_rf_read || (redirect && !i_stall)) begin
               pc_d       = pc_in_br;
               rf_pc_d    = pc_q;
               rf_valid_d = 1'b0;
               state_d    = S_REDIRECT;
            end else if (i_stall) begin
               state_d = S_STALL;
            end else begin
               pc_d       = next_pc;
               rf_pc_d    = pc_q;
               rf_valid_d = 1'b1;
               state_d    = S_RUN;
            end
         end
         S_STALL: begin
            fetch_valid = 1'b1;
            if (set_invalid_sig_to_rf_read) begin
               pc_d       = pc_in_br;
               rf_valid_d = 1'b0;
               state_d    = S_REDIRECT;
            end else if (!i_stall) begin
               state_d = S_RUN;
            end
         end
         default: begin
            state_d = S_RESET;
         end
      endcase
      if (set_invalid_sig_to_rf_read) begin
         rf_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q       <= S_RESET;
         pc_q          <= RESET_PC;
         rf_pc_q       <= '0;
         rf_valid_q    <= 1'b0;
         after_stall_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         rf_pc_q       <= rf_pc_d;
         rf_valid_q    <= rf_valid_d;
         after_stall_q <= (state_q == S_STALL);
      end
   end

   // Imem returns the re-read fetch word during a stall and on the cycle after release,
   // so the rf_read IR comes from the hold register for that whole window.
   assign select  = (state_q == S_STALL) || after_stall_q;
   assign capture = (state_d == S_STALL) && (state_q != S_STALL) && !select;

   fetch_ir_hold u_ir_hold (
      .clk          (clk),
      .reset        (reset),
      .capture      (capture),
      .select       (select),
      .i_mem_rddata (mem.i_mem_rddata),
      .ir           (o_ir_in_rf_read_stage)
   );

   assign mem.o_mem_addr = pc_q;
   assign mem.o_mem_rd   = reset;

   assign o_pc_out_in_fetch_stage  = pc_q;
   assign o_valid_in_fetch_stage   = fetch_valid;
   assign o_pc_in_rf_read_stage    = rf_pc_q;
   assign o_valid_in_rf_read_stage = rf_valid_q;
   assign o_state                  = state_q;

`ifdef FETCH_PERF_CNT_EN
   logic advance, redirect_taken;
   logic [15:0] fetch_cnt_q, redirect_cnt_q;

   // From RUN/REDIRECT the only path back into RUN is a normal advance.
   assign advance        = ((state_q == S_RUN) || (state_q == S_REDIRECT)) && (state_d == S_RUN);
   assign redirect_taken = (state_d == S_REDIRECT);

   always_ff @(posedge clk) begin
      if (!reset) begin
         fetch_cnt_q    <= '0;
         redirect_cnt_q <= '0;
      end else begin
         if (advance)        fetch_cnt_q    <= sat_inc(fetch_cnt_q);
         if (redirect_taken) redirect_cnt_q <= sat_inc(redirect_cnt_q);
      end
   end

   assign o_fetch_cnt    = fetch_cnt_q;
   assign o_redirect_cnt = redirect_cnt_q;
`endif

endmodule
